// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-press operand loader with key debounce and valid/ready offer
// Optional debouncers: OPERAND_ENTRY_DEBOUNCE_EN (undefined: debounced level = synchronized level)
module operand_entry #(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset_n,
  input  logic [7:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] inputx,
  output logic [3:0] inputy,
  output logic       sub,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] state_led
);

  typedef enum logic [1:0] {
    CAP_X = 2'b00,
    CAP_Y = 2'b01,
    OFFER = 2'b10,
    DONE  = 2'b11
  } state_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_s1_q, key_s2_q;
  logic [7:0] sw_s1_q, sw_s2_q;
  logic [1:0] deb_w;
  logic [1:0] deb_dly_q;
  logic [1:0] press_q;
  logic       cap_press, clr_press;
  logic       unused_sw;

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic       sub_q, sub_d;

  assign clk   = MAX10_CLK1_50;
  assign rst_n = reset_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
      sw_s1_q  <= 8'h00;
      sw_s2_q  <= 8'h00;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign unused_sw = ^sw_s2_q[6:4];

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = DEBOUNCE_CYCLES - 1'b1;

  for (genvar k = 0; k < 2; k++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (key_s2_q[k] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q >= DEB_LAST) begin
        cnt_d = '0;
        lvl_d = key_s2_q[k];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign deb_w[k] = lvl_q;
  end
`else
  logic [CNT_W-1:0] unused_debounce_cfg;
  assign unused_debounce_cfg = DEBOUNCE_CYCLES;
  assign deb_w = key_s2_q;
`endif

  // Press is a registered one-cycle pulse on the debounced 1->0 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_dly_q <= 2'b11;
      press_q   <= 2'b00;
    end else begin
      deb_dly_q <= deb_w;
      press_q   <= deb_dly_q & ~deb_w;
    end
  end

  assign clr_press = press_q[0];
  assign cap_press = press_q[1];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sub_d   = sub_q;
    if (clr_press) begin
      state_d = CAP_X;
      x_d     = 4'h0;
      y_d     = 4'h0;
      sub_d   = 1'b0;
    end else begin
      case (state_q)
        CAP_X: if (cap_press) begin
          x_d     = sw_s2_q[3:0];
          state_d = CAP_Y;
        end
        CAP_Y: if (cap_press) begin
          y_d     = sw_s2_q[3:0];
          sub_d   = sw_s2_q[7];
          state_d = OFFER;
        end
        OFFER: if (op_ready) begin
          state_d = DONE;
        end
        DONE: if (cap_press) begin
          x_d     = sw_s2_q[3:0];
          state_d = CAP_Y;
        end
        default: state_d = CAP_X;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAP_X;
      x_q     <= 4'h0;
      y_q     <= 4'h0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sub_q   <= sub_d;
    end
  end

  assign inputx    = x_q;
  assign inputy    = y_q;
  assign sub       = sub_q;
  assign op_valid  = (state_q == OFFER);
  assign state_led = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - randomized self-checking bench for operand_entry against a transaction model
module tb_operand_entry;

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [1:0] key = 2'b11;
  logic       op_ready = 1'b0;
  logic [3:0] inputx, inputy;
  logic       sub, op_valid;
  logic [1:0] state_led;

  operand_entry #(.CNT_W(16), .DEBOUNCE_CYCLES(16'd4)) dut (
    .MAX10_CLK1_50(clk),
    .reset_n      (rst_n),
    .SW           (sw),
    .KEY          (key),
    .inputx       (inputx),
    .inputy       (inputy),
    .sub          (sub),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .state_led    (state_led)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int transfers = 0;

  always @(negedge clk) begin
    if (op_valid) valid_cycles++;
    if (op_valid && op_ready) transfers++;
  end

  // Transaction-level model: phase 0=X, 1=Y, 2=offer, 3=done
  int         m_phase = 0;
  logic [3:0] m_x = 4'h0, m_y = 4'h0;
  logic       m_sub = 1'b0;
  int         m_xfers = 0;

  wire [14:0] obs = {state_led, op_valid, sub, inputy, inputx};

  function automatic logic [14:0] expv();
    logic [1:0] ph;
    ph = m_phase[1:0];
    return {ph, (m_phase == 2), m_sub, m_y, m_x};
  endfunction

  task automatic model_clear();
    m_phase = 0; m_x = 4'h0; m_y = 4'h0; m_sub = 1'b0;
  endtask

  task automatic model_capture(input logic [7:0] v);
    case (m_phase)
      0, 3: begin m_x = v[3:0]; m_phase = 1; end
      1: begin m_y = v[3:0]; m_sub = v[7]; m_phase = 2; end
      default: ;
    endcase
  endtask

  task automatic model_handshake();
    if (m_phase == 2 && op_ready) begin
      m_phase = 3;
      m_xfers++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press the keys in mask (bit1 capture, bit0 clear) with SW preset; report when the state first moved.
  task automatic press(input logic [1:0] mask, input logic [7:0] v,
                       output int first_change, output int exp_first);
    logic [1:0] prev;
    sw = v;
    repeat (3) tick();
    if (mask[0]) exp_first = (m_phase != 0) ? LAT + 1 : 0;
    else         exp_first = (m_phase != 2) ? LAT + 1 : 0;
    prev = state_led;
    first_change = 0;
    key = 2'b11 & ~mask;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      if (first_change == 0 && state_led !== prev) first_change = i;
    end
    key = 2'b11;
    repeat (LAT + 3) tick();
    if (mask[0]) model_clear();
    else if (mask[1]) model_capture(v);
    model_handshake();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 15'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, 15'h0);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== 15'h0) begin
      errors++;
      $display("FAIL reset_released: got %h expected %h", obs, 15'h0);
    end
  endtask

  task automatic test_basic();
    int fc, ef, v0, t0;
    press(2'b10, 8'h03, fc, ef);
    checks++;
    if (fc !== ef) begin errors++; $display("FAIL basic_x_latency: got %0d expected %0d", fc, ef); end
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL basic_x: got %h expected %h", obs, expv()); end
    op_ready = 1'b1;
    v0 = valid_cycles;
    t0 = transfers;
    press(2'b10, 8'h05, fc, ef);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b0, 4'h5, 4'h3}) begin
      errors++; $display("FAIL basic_result: got %h expected %h", obs, {2'b11, 1'b0, 1'b0, 4'h5, 4'h3});
    end
    checks++;
    if (valid_cycles - v0 !== 1) begin
      errors++; $display("FAIL basic_valid_width: got %0d expected 1", valid_cycles - v0);
    end
    checks++;
    if (transfers - t0 !== 1) begin
      errors++; $display("FAIL basic_transfers: got %0d expected 1", transfers - t0);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_subtract();
    int fc, ef;
    press(2'b10, 8'($urandom_range(0, 255)), fc, ef);
    press(2'b10, 8'h82, fc, ef);
    checks++;
    if (obs !== expv() || inputy !== 4'h2 || sub !== 1'b1) begin
      errors++; $display("FAIL sub_capture: got %h expected %h", obs, expv());
    end
    op_ready = 1'b1;
    tick();
    model_handshake();
    op_ready = 1'b0;
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL sub_done: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_backpressure();
    int fc, ef, v0, bad;
    press(2'b10, 8'($urandom), fc, ef);
    press(2'b10, 8'($urandom), fc, ef);
    v0 = valid_cycles;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      sw = 8'($urandom);
      if (i == 10) key[1] = 1'b0;
      if (i == 10 + LAT + 3) key[1] = 1'b1;
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL bp_hold cycle %0d: got %h expected %h", i, obs, expv());
      end
    end
    checks++;
    if (valid_cycles - v0 !== 50) begin
      errors++; $display("FAIL bp_valid_cycles: got %0d expected 50", valid_cycles - v0);
    end
    op_ready = 1'b1;
    tick();
    model_handshake();
    op_ready = 1'b0;
    checks++;
    if (obs !== expv() || m_phase != 3) begin
      errors++; $display("FAIL bp_release: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_simultaneous();
    int fc, ef;
    press(2'b10, 8'($urandom_range(1, 255)), fc, ef);
    press(2'b11, 8'($urandom), fc, ef);
    checks++;
    if (fc !== ef) begin errors++; $display("FAIL simul_latency: got %0d expected %0d", fc, ef); end
    checks++;
    if (obs !== 15'h0) begin errors++; $display("FAIL simul_clear: got %h expected %h", obs, 15'h0); end
  endtask

  task automatic test_bounce();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    int early, n;
    logic [1:0] prev;
    logic [7:0] v;
    v = 8'($urandom);
    sw = v;
    repeat (3) tick();
    prev = state_led;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      key[1] = (i % 2 == 1);
      repeat (2) begin
        tick();
        if (state_led !== prev) early++;
      end
    end
    key[1] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (n == 0 && state_led !== prev) n = i;
    end
    key[1] = 1'b1;
    repeat (LAT + 3) tick();
    model_capture(v);
    checks++;
    if (early !== 0) begin errors++; $display("FAIL bounce_early: got %0d expected 0", early); end
    checks++;
    if (n !== LAT + 1) begin errors++; $display("FAIL bounce_latency: got %0d expected %0d", n, LAT + 1); end
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL bounce_state: got %h expected %h", obs, expv()); end
`endif
  endtask

  task automatic test_reset_offer();
    int fc, ef, t0;
    for (int i = 0; i < 3 && m_phase != 2; i++) press(2'b10, 8'($urandom), fc, ef);
    checks++;
    if (op_valid !== 1'b1) begin errors++; $display("FAIL rst_offer_setup: got %b expected 1", op_valid); end
    t0 = transfers;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs !== 15'h0) begin errors++; $display("FAIL rst_offer_async: got %h expected %h", obs, 15'h0); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (transfers !== t0) begin errors++; $display("FAIL rst_offer_xfer: got %0d expected %0d", transfers, t0); end
    op_ready = 1'b1;
    press(2'b10, 8'($urandom), fc, ef);
    press(2'b10, 8'($urandom), fc, ef);
    op_ready = 1'b0;
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL rst_offer_after: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_random();
    int fc, ef;
    for (int it = 0; it < 8; it++) begin
      op_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) press(2'b01, 8'($urandom), fc, ef);
      else press(2'b10, 8'($urandom), fc, ef);
      checks++;
      if (fc !== ef) begin errors++; $display("FAIL rand_latency %0d: got %0d expected %0d", it, fc, ef); end
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL rand_state %0d: got %h expected %h", it, obs, expv()); end
      if (m_phase == 2) begin
        op_ready = 1'b0;
        repeat ($urandom_range(0, 5)) tick();
        op_ready = 1'b1;
        tick();
        model_handshake();
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL rand_handshake %0d: got %h expected %h", it, obs, expv()); end
      end
      op_ready = 1'b0;
    end
    checks++;
    if (transfers !== m_xfers) begin errors++; $display("FAIL rand_transfers: got %0d expected %0d", transfers, m_xfers); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_subtract();
    test_backpressure();
    test_simultaneous();
    test_bounce();
    test_reset_offer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
